// File: rtl/descriptor_unpack_stream_if.sv
// descriptor_unpack_stream_if: command, memory-beat and decoded-result handshakes of the descriptor unpacker
interface descriptor_unpack_stream_if #(
  parameter int PA_WIDTH = 24,
  parameter int LIMIT_WIDTH = 15
);
  logic cmd_valid_i;
  logic cmd_ready_o;
  logic [1:0] cmd_kind_i;
  logic cmd_long_i;
  logic beat_valid_i;
  logic beat_ready_o;
  logic [31:0] beat_data_i;
  logic out_valid_o;
  logic out_ready_i;
  logic [1:0] kind_o;
  logic long_o;
  logic [1:0] dt_o;
  logic lu_o;
  logic [LIMIT_WIDTH-1:0] limit_o;
  logic s_o;
  logic ci_o;
  logic m_o;
  logic u_o;
  logic wp_o;
  logic [PA_WIDTH-1:0] addr_o;
  logic invalid_o;
  logic err_o;
  modport slave (
    input cmd_valid_i, cmd_kind_i, cmd_long_i, beat_valid_i, beat_data_i, out_ready_i,
    output cmd_ready_o, beat_ready_o, out_valid_o, kind_o, long_o, dt_o, lu_o, limit_o,
    output s_o, ci_o, m_o, u_o, wp_o, addr_o, invalid_o, err_o
  );
  modport master (
    output cmd_valid_i, cmd_kind_i, cmd_long_i, beat_valid_i, beat_data_i, out_ready_i,
    input cmd_ready_o, beat_ready_o, out_valid_o, kind_o, long_o, dt_o, lu_o, limit_o,
    input s_o, ci_o, m_o, u_o, wp_o, addr_o, invalid_o, err_o
  );
endinterface

// File: rtl/descriptor_unpack_stream.sv
// descriptor_unpack_stream: assembles one or two memory beats into a short/long 68851 descriptor and decodes it
module descriptor_unpack_stream #(
  parameter int PA_WIDTH = 24,
  parameter int LIMIT_WIDTH = 15,
  parameter int PAGE_SHIFT = 12
) (
  input logic clk_i,
  input logic rst_i,
  descriptor_unpack_stream_if.slave bus
);
  typedef enum logic [1:0] {IDLE, W0, W1, OUT} state_t;
  typedef struct packed {
    logic [1:0] kind;
    logic lng;
    logic [1:0] dt;
    logic lu;
    logic [LIMIT_WIDTH-1:0] limit;
    logic s;
    logic ci;
    logic m;
    logic u;
    logic wp;
    logic [PA_WIDTH-1:0] addr;
    logic invalid;
    logic err;
  } fld_t;
  localparam logic [31:0] PAGE_MASK = ~((32'd1 << PAGE_SHIFT) - 32'd1);
  localparam logic [31:0] TABLE_MASK = 32'hFFFF_FFF0;
  state_t state_q, state_d, cmd_st;
  logic [1:0] kind_q;
  logic long_q;
  logic [31:0] w0_q;
  fld_t out_q, out_d, dec, err_f;
  logic cmd_fire, beat_fire, out_fire, cmd_long_eff, page;
  logic [31:0] w0, addr;
  wire unused_bits = ^{w0, addr};
  assign cmd_fire = bus.cmd_valid_i & bus.cmd_ready_o;
  assign beat_fire = bus.beat_valid_i & bus.beat_ready_o;
  assign out_fire = bus.out_valid_o & bus.out_ready_i;
  assign bus.cmd_ready_o = ~rst_i & ((state_q == IDLE) | ((state_q == OUT) & bus.out_ready_i));
  assign bus.beat_ready_o = (state_q == W0) | (state_q == W1);
  assign bus.out_valid_o = state_q == OUT;
  assign cmd_long_eff = bus.cmd_long_i | (bus.cmd_kind_i == 2'd0);
  assign cmd_st = (bus.cmd_kind_i == 2'd3) ? OUT : W0;
  // word0 is the live beat for short descriptors, the latched one once word1 is arriving
  always_comb begin
    w0 = (state_q == W1) ? w0_q : bus.beat_data_i;
    page = kind_q == 2'd2;
    addr = (long_q ? bus.beat_data_i : w0) & (page ? PAGE_MASK : TABLE_MASK);
    dec = '0;
    dec.kind = kind_q;
    dec.lng = long_q;
    dec.dt = w0[1:0];
    dec.wp = w0[2];
    dec.u = w0[3];
    dec.m = page & w0[4];
    dec.ci = page & w0[6];
    dec.lu = long_q & w0[31];
    dec.limit = long_q ? w0[16 +: LIMIT_WIDTH] : '0;
    dec.s = long_q & w0[8];
    dec.addr = addr[PA_WIDTH-1:0];
    dec.invalid = w0[1:0] == 2'd0;
    err_f = '0;
    err_f.kind = bus.cmd_kind_i;
    err_f.lng = cmd_long_eff;
    err_f.err = 1'b1;
  end
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    unique case (state_q)
      IDLE: state_d = cmd_fire ? cmd_st : IDLE;
      W0: state_d = beat_fire ? (long_q ? W1 : OUT) : W0;
      W1: state_d = beat_fire ? OUT : W1;
      OUT: state_d = out_fire ? (cmd_fire ? cmd_st : IDLE) : OUT;
      default: state_d = IDLE;
    endcase
    if (beat_fire && (state_q == W1 || !long_q)) out_d = dec;
    if (cmd_fire && bus.cmd_kind_i == 2'd3) out_d = err_f;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      kind_q <= '0;
      long_q <= 1'b0;
      w0_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      if (cmd_fire) begin
        kind_q <= bus.cmd_kind_i;
        long_q <= cmd_long_eff;
      end
      if (beat_fire && state_q == W0) w0_q <= bus.beat_data_i;
    end
  end
  assign bus.kind_o = out_q.kind;
  assign bus.long_o = out_q.lng;
  assign bus.dt_o = out_q.dt;
  assign bus.lu_o = out_q.lu;
  assign bus.limit_o = out_q.limit;
  assign bus.s_o = out_q.s;
  assign bus.ci_o = out_q.ci;
  assign bus.m_o = out_q.m;
  assign bus.u_o = out_q.u;
  assign bus.wp_o = out_q.wp;
  assign bus.addr_o = out_q.addr;
  assign bus.invalid_o = out_q.invalid;
  assign bus.err_o = out_q.err;
endmodule

// File: doc/descriptor_unpack_stream.md
# descriptor_unpack_stream

Sequential descriptor unpacker for the table-walk datapath. It accepts a walk command (descriptor kind and short/long format), consumes one or two 32-bit memory beats over a valid/ready stream, and decodes the 68851 short (32-bit) or long (64-bit) root/pointer/page descriptor into a unified field bundle. The bundle is presented behind an output valid/ready handshake. It generalises the combinational pack/unpack block with multi-beat assembly, format selection per command, flow control and error flagging, and sits between the bus read port and the walker FSM.

## Interface
- PA_WIDTH, 24, physical address width; 12..32.
- LIMIT_WIDTH, 15, limit bits kept; 1..15, taken from word0[16+LIMIT_WIDTH-1:16].
- PAGE_SHIFT, 12, page size log2; 8..PA_WIDTH-1.
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake.
- cmd_kind_i  in  2  0 = root, 1 = pointer, 2 = page, 3 = reserved.
- cmd_long_i  in  1  1 = long format (2 beats), 0 = short (1 beat).
- beat_valid_i / beat_ready_o  in/out  1  memory beat handshake.
- beat_data_i  in  32  descriptor word; the high word (word0) arrives first.
- out_valid_o / out_ready_i  out/in  1  result handshake.
- kind_o 2, long_o 1, dt_o 2, lu_o 1, limit_o LIMIT_WIDTH, s_o 1, ci_o 1, m_o 1, u_o 1, wp_o 1, addr_o PA_WIDTH  out  decoded fields.
- invalid_o  out  1  DT == 0.
- err_o  out  1  reserved kind.

## Operation
- FSM states:
  - IDLE: cmd_ready_o = 1 (forced 0 while rst_i is high).
  - W0 / W1: beat_ready_o = 1.
  - OUT: out_valid_o = 1.
- Command handshake: cmd_valid_i & cmd_ready_o captures the kind and the effective long flag. A root command is always treated as long, whatever cmd_long_i says.
- Kinds 0..2: go to W0.
- Kind 3: goes straight to OUT with err_o = 1. No beats are consumed and all fields are 0.
- W0 + beat handshake: latch word0. Long format goes to W1; short format goes to OUT.
- W1 + beat handshake: latch word1, then go to OUT.
- OUT + out_ready_i: go to IDLE. cmd_ready_o is also high in OUT when out_ready_i = 1, so a back-to-back command goes OUT → W0 directly.
- Decode from word0, all formats: dt = [1:0], wp = [2], u = [3].
- Decode, page kind only: m = [4], ci = [6]. These are 0 for table kinds.
- Decode, long only: lu = [31], limit = [30:16] truncated to LIMIT_WIDTH, s = [8]. These are 0 for short.
- Address, short table: word0 & ~0xF.
- Address, short page: word0 & ~((1<<PAGE_SHIFT)-1).
- Address, long format: same masks applied to word1.
- addr_o is the address truncated to PA_WIDTH.
- invalid_o = (dt == 0), for kinds 0..2 only.
- Output registers hold stable while out_valid_o = 1 and out_ready_i = 0.
- Beats are ignored (beat_ready_o = 0) in IDLE and OUT.

## Timing
- Reset: state IDLE. All outputs 0 (cmd_ready_o gated 0 during the reset cycle). Takes effect on the clock edge with rst_i high.
- Reset mid-operation discards any partial word0. The next command starts fresh.
- Latency from cmd accept at edge N with beats always valid:
  - Short: beat at N+1, out_valid_o at N+2.
  - Long: beats at N+1 and N+2, out_valid_o at N+3.
  - Kind 3: out_valid_o at N+1.
- Sustained throughput with out_ready_i tied high: one short descriptor per 2 cycles, one long descriptor per 3 cycles.
- Beat stalls (beat_valid_i = 0) extend W0/W1 indefinitely. There is no timeout.
- Output fields change only on the transition into OUT.

## Test plan
- Short page: cmd kind 2, long 0; beat 0x00123459.
  - Expect dt = 1, wp = 0, u = 1, m = 1, ci = 1, addr_o = 0x123000.
  - Expect invalid_o = 0, out_valid_o two cycles after cmd accept.
- Root, issued with cmd_long_i = 0: beats 0x80050102 then 0x00ABCDE7.
  - Expect long_o = 1 (root forces long), lu = 1, limit = 0x0005, s = 1, dt = 2, addr_o = 0xABCDE0.
  - Expect out_valid_o three cycles after cmd accept.
- Short pointer with DT = 0: beat 0x00456780.
  - Expect invalid_o = 1, addr_o = 0x456780, err_o = 0.
- Reserved kind 3 with beat_valid_i held high:
  - Expect err_o = 1 and out_valid_o the next cycle.
  - Expect beat_ready_o to stay 0, so no beat is consumed.
- Backpressure: out_ready_i low for 5 cycles, then a back-to-back command presented in OUT.
  - Expect fields stable and beat_ready_o = 0 while stalled.
  - Expect the next command to be accepted in the same cycle as the output handshake.
- Reset after word0 of a long pointer has been accepted, then a new short page command.
  - Expect out_valid_o = 0 through the reset.
  - Expect the decode to use only the new beat.
